// File: rtl/seq_divider_ctrl_pkg.sv
// Shared types and constants for the sequential restoring divider.
// No logic: state encoding, default width and counter-width helper only.
// Optional divide-by-zero detection is selected by DIV_ZERO_DETECT_EN.
package seq_divider_pkg;

   localparam int DIV_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Width of a counter that must hold WIDTH-1; at least one bit.
   function automatic int div_cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/seq_divider_ctrl_if.sv
// Operand/result bundle between the operand source, the divider and the result consumer.
// Latency: none, wires only.
// Backpressure: none; start is only honoured while the divider is idle.
// div_err exists only when DIV_ZERO_DETECT_EN is defined.
interface seq_divider_ctrl_if
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DIV_DEFAULT_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
   logic             div_err;
`endif

   // Operand source / result consumer side
   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder
`ifdef DIV_ZERO_DETECT_EN
      , input div_err
`endif
   );

   // Divider side
   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder
`ifdef DIV_ZERO_DETECT_EN
      , output div_err
`endif
   );

endinterface

// File: rtl/seq_divider_ctrl_iter_counter.sv
// Loadable up/down iteration counter with a combinational zero flag.
// Latency: load/count takes effect on the next rising edge; zflag follows the count.
// Backpressure: none; counts only while ce is high, ld has priority over counting.
module div_iter_counter #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             ld,
   input  logic             ud,
   input  logic [CNT_W-1:0] D,
   output logic             zflag
);

   logic [CNT_W-1:0] r_count;

   // Load, increment or decrement the count when enabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (ce) begin
         if (ld) begin
            r_count <= D;
         end else if (ud) begin
            r_count <= r_count + CNT_W'(1);
         end else begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   assign zflag = (r_count == '0);

endmodule

// File: rtl/seq_divider_ctrl.sv
// Unsigned restoring sequential divider, one quotient bit per clock (DIV_ZERO_DETECT_EN adds div_err).
// Latency: done WIDTH+1 cycles after an accepted start (1 cycle for a zero divisor with detection on).
// Backpressure: start is accepted only in IDLE; starts while busy (incl. DONE) are dropped, not queued.
module seq_divider_ctrl
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   seq_divider_ctrl_if.slave bus
);

   localparam int               CNT_W    = div_cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

   div_state_t       r_state;
   logic [WIDTH:0]   r_rem;      // partial remainder, one guard bit for the trial subtract
   logic [WIDTH-1:0] r_q;        // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] r_d;        // captured divisor
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
`ifdef DIV_ZERO_DETECT_EN
   logic             r_div_err;
   logic             w_div_zero;
`endif

   logic             w_accept;
   logic             w_ld;
   logic             w_ce;
   logic             w_zflag;
   logic [2*WIDTH:0] w_rq_shift;
   logic [WIDTH:0]   w_r_shift;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH:0]   w_r_next;
   logic [WIDTH-1:0] w_q_next;

   assign w_accept = (r_state == IDLE) && bus.start;
   assign w_ld     = w_accept;
   assign w_ce     = w_accept || (r_state == CALC);

`ifdef DIV_ZERO_DETECT_EN
   assign w_div_zero = (bus.divisor == '0);
`endif

   // One restoring step: shift {R,Q} left, trial-subtract D, keep the result if non-negative
   always_comb begin
      w_rq_shift = {r_rem, r_q} << 1;
      w_r_shift  = w_rq_shift[2*WIDTH:WIDTH];
      w_trial    = w_r_shift - {1'b0, r_d};
      w_r_next   = w_r_shift;
      w_q_next   = w_rq_shift[WIDTH-1:0];
      if (!w_trial[WIDTH]) begin
         w_r_next = w_trial;
         w_q_next = {w_rq_shift[WIDTH-1:1], 1'b1};
      end
   end

   // Iteration counter runs down from WIDTH-1; its zero flag marks the last CALC step
   div_iter_counter #(
      .CNT_W (CNT_W)
   ) u_iter_cnt (
      .clk   (clk),
      .rst   (rst),
      .ce    (w_ce),
      .ld    (w_ld),
      .ud    (1'b0),
      .D     (CNT_LOAD),
      .zflag (w_zflag)
   );

   // Control FSM with datapath registers and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_rem       <= '0;
         r_q         <= '0;
         r_d         <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
         r_div_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_q     <= bus.dividend;
                  r_d     <= bus.divisor;
                  r_rem   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= CALC;
`ifdef DIV_ZERO_DETECT_EN
                  r_div_err <= 1'b0;
                  if (w_div_zero) begin
                     // Result is known up front: skip the iterations entirely
                     r_state     <= DONE;
                     r_done      <= 1'b1;
                     r_quotient  <= '1;
                     r_remainder <= bus.dividend;
                     r_div_err   <= 1'b1;
                  end
`endif
               end
            end
            CALC: begin
               r_rem <= w_r_next;
               r_q   <= w_q_next;
               if (w_zflag) begin
                  // Last step: publish the final step's results so they are valid with done
                  r_quotient  <= w_q_next;
                  r_remainder <= w_r_next[WIDTH-1:0];
                  r_done      <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.quotient  = r_quotient;
   assign bus.remainder = r_remainder;
`ifdef DIV_ZERO_DETECT_EN
   assign bus.div_err   = r_div_err;
`endif

endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Directed bench for seq_divider_ctrl at WIDTH=8.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Zero-divisor expectations follow DIV_ZERO_DETECT_EN.
module tb_seq_divider_ctrl;

   logic clk;
   logic rst;
   int   chk_cnt;
   int   pass_cnt;

   seq_divider_ctrl_if #(.WIDTH(8)) bus ();

   seq_divider_ctrl #(
      .WIDTH (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one divide in an idle cycle and wait (bounded) for done.
   // lat = cycles from start acceptance to done (-1 if never seen).
   task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int bcnt,
                          output logic [7:0] q, output logic [7:0] r);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      step();
      bus.start    = 1'b0;
      bus.dividend = 8'h5A;
      bus.divisor  = 8'hC3;
      lat  = -1;
      bcnt = 0;
      for (int n = 1; n <= 40; n++) begin
         if (bus.busy === 1'b1) bcnt++;
         if (bus.done === 1'b1) begin
            lat = n;
            break;
         end
         step();
      end
      q = bus.quotient;
      r = bus.remainder;
   endtask

   task automatic test_reset();
      chk_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy); else pass_cnt++;
      chk_cnt++;
      if (bus.done !== 1'b0) $display("FAIL reset_done got=%b want=0", bus.done); else pass_cnt++;
      chk_cnt++;
      if (bus.quotient !== 8'd0) $display("FAIL reset_quotient got=%0d want=0", bus.quotient); else pass_cnt++;
      chk_cnt++;
      if (bus.remainder !== 8'd0) $display("FAIL reset_remainder got=%0d want=0", bus.remainder); else pass_cnt++;
`ifdef DIV_ZERO_DETECT_EN
      chk_cnt++;
      if (bus.div_err !== 1'b0) $display("FAIL reset_div_err got=%b want=0", bus.div_err); else pass_cnt++;
`endif
   endtask

   task automatic test_basic();
      int lat, bcnt;
      logic [7:0] q, r;
      run_div(8'd100, 8'd7, lat, bcnt, q, r);
      chk_cnt++;
      if (lat != 9) $display("FAIL basic_latency got=%0d want=9", lat); else pass_cnt++;
      chk_cnt++;
      if (q !== 8'd14) $display("FAIL basic_quotient got=%0d want=14", q); else pass_cnt++;
      chk_cnt++;
      if (r !== 8'd2) $display("FAIL basic_remainder got=%0d want=2", r); else pass_cnt++;
      chk_cnt++;
      if (bcnt != 9) $display("FAIL basic_busy_cycles got=%0d want=9", bcnt); else pass_cnt++;
      step();
      chk_cnt++;
      if (bus.done !== 1'b0) $display("FAIL basic_done_pulse got=%b want=0", bus.done); else pass_cnt++;
      chk_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL basic_busy_after got=%b want=0", bus.busy); else pass_cnt++;
      chk_cnt++;
      if (bus.quotient !== 8'd14) $display("FAIL basic_quotient_hold got=%0d want=14", bus.quotient); else pass_cnt++;
   endtask

   task automatic test_patterns();
      int lat, bcnt;
      logic [7:0] q, r;
      run_div(8'd255, 8'd1, lat, bcnt, q, r);
      step();
      chk_cnt++;
      if (q !== 8'd255) $display("FAIL p255_1_quotient got=%0d want=255", q); else pass_cnt++;
      chk_cnt++;
      if (r !== 8'd0) $display("FAIL p255_1_remainder got=%0d want=0", r); else pass_cnt++;
      run_div(8'd5, 8'd9, lat, bcnt, q, r);
      step();
      chk_cnt++;
      if (q !== 8'd0) $display("FAIL p5_9_quotient got=%0d want=0", q); else pass_cnt++;
      chk_cnt++;
      if (r !== 8'd5) $display("FAIL p5_9_remainder got=%0d want=5", r); else pass_cnt++;
      chk_cnt++;
      if (lat != 9) $display("FAIL p5_9_latency got=%0d want=9", lat); else pass_cnt++;
      run_div(8'd250, 8'd250, lat, bcnt, q, r);
      step();
      chk_cnt++;
      if (q !== 8'd1) $display("FAIL p250_250_quotient got=%0d want=1", q); else pass_cnt++;
      chk_cnt++;
      if (r !== 8'd0) $display("FAIL p250_250_remainder got=%0d want=0", r); else pass_cnt++;
   endtask

   task automatic test_div_zero();
      int lat, bcnt;
      logic [7:0] q, r;
      run_div(8'd77, 8'd0, lat, bcnt, q, r);
      chk_cnt++;
      if (q !== 8'd255) $display("FAIL dz_quotient got=%0d want=255", q); else pass_cnt++;
      chk_cnt++;
      if (r !== 8'd77) $display("FAIL dz_remainder got=%0d want=77", r); else pass_cnt++;
`ifdef DIV_ZERO_DETECT_EN
      chk_cnt++;
      if (lat != 1) $display("FAIL dz_latency got=%0d want=1", lat); else pass_cnt++;
      chk_cnt++;
      if (bus.div_err !== 1'b1) $display("FAIL dz_div_err got=%b want=1", bus.div_err); else pass_cnt++;
      step();
      chk_cnt++;
      if (bus.div_err !== 1'b1) $display("FAIL dz_div_err_hold got=%b want=1", bus.div_err); else pass_cnt++;
      run_div(8'd100, 8'd7, lat, bcnt, q, r);
      chk_cnt++;
      if (bus.div_err !== 1'b0) $display("FAIL dz_div_err_clear got=%b want=0", bus.div_err); else pass_cnt++;
      chk_cnt++;
      if (q !== 8'd14) $display("FAIL dz_next_quotient got=%0d want=14", q); else pass_cnt++;
      step();
`else
      chk_cnt++;
      if (lat != 9) $display("FAIL dz_latency got=%0d want=9", lat); else pass_cnt++;
      step();
`endif
   endtask

   task automatic test_ignore_start();
      int lat;
      lat = -1;
      bus.start    = 1'b1;
      bus.dividend = 8'd100;
      bus.divisor  = 8'd7;
      step();                       // t+1
      bus.start    = 1'b0;
      step();                       // t+2
      step();                       // t+3
      bus.start    = 1'b1;
      bus.dividend = 8'd200;
      bus.divisor  = 8'd13;
      step();                       // t+4
      bus.start    = 1'b0;
      for (int n = 4; n <= 40; n++) begin
         if (bus.done === 1'b1) begin
            lat = n;
            break;
         end
         step();
      end
      chk_cnt++;
      if (lat != 9) $display("FAIL ignore_latency got=%0d want=9", lat); else pass_cnt++;
      chk_cnt++;
      if (bus.quotient !== 8'd14) $display("FAIL ignore_quotient got=%0d want=14", bus.quotient); else pass_cnt++;
      chk_cnt++;
      if (bus.remainder !== 8'd2) $display("FAIL ignore_remainder got=%0d want=2", bus.remainder); else pass_cnt++;
      step();
   endtask

   task automatic test_back_to_back();
      int lat, bcnt;
      logic [7:0] q, r;
      run_div(8'd100, 8'd7, lat, bcnt, q, r);
      // start raised during DONE with decoy operands must be dropped
      bus.start    = 1'b1;
      bus.dividend = 8'd50;
      bus.divisor  = 8'd3;
      step();
      chk_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL b2b_idle_busy got=%b want=0", bus.busy); else pass_cnt++;
      // start kept high into the IDLE cycle with the real operands
      run_div(8'd200, 8'd13, lat, bcnt, q, r);
      chk_cnt++;
      if (lat != 9) $display("FAIL b2b_latency got=%0d want=9", lat); else pass_cnt++;
      chk_cnt++;
      if (q !== 8'd15) $display("FAIL b2b_quotient got=%0d want=15", q); else pass_cnt++;
      chk_cnt++;
      if (r !== 8'd5) $display("FAIL b2b_remainder got=%0d want=5", r); else pass_cnt++;
      step();
   endtask

   task automatic test_reset_mid();
      int lat, bcnt;
      logic [7:0] q, r;
      bus.start    = 1'b1;
      bus.dividend = 8'd100;
      bus.divisor  = 8'd7;
      step();                       // t+1
      bus.start    = 1'b0;
      step();                       // t+2
      step();                       // t+3
      step();                       // t+4
      rst = 1'b1;
      #1;
      chk_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL midrst_busy got=%b want=0", bus.busy); else pass_cnt++;
      chk_cnt++;
      if (bus.done !== 1'b0) $display("FAIL midrst_done got=%b want=0", bus.done); else pass_cnt++;
      chk_cnt++;
      if (bus.quotient !== 8'd0) $display("FAIL midrst_quotient got=%0d want=0", bus.quotient); else pass_cnt++;
      chk_cnt++;
      if (bus.remainder !== 8'd0) $display("FAIL midrst_remainder got=%0d want=0", bus.remainder); else pass_cnt++;
      step();
      rst = 1'b0;
      step();
      run_div(8'd200, 8'd13, lat, bcnt, q, r);
      chk_cnt++;
      if (lat != 9) $display("FAIL midrst_next_latency got=%0d want=9", lat); else pass_cnt++;
      chk_cnt++;
      if (q !== 8'd15) $display("FAIL midrst_next_quotient got=%0d want=15", q); else pass_cnt++;
      chk_cnt++;
      if (r !== 8'd5) $display("FAIL midrst_next_remainder got=%0d want=5", r); else pass_cnt++;
      step();
   endtask

   initial begin
      chk_cnt      = 0;
      pass_cnt     = 0;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = 8'd0;
      bus.divisor  = 8'd0;
      #2;
      test_reset();
      step();
      rst = 1'b0;
      step();
      test_basic();
      test_patterns();
      test_div_zero();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/seq_divider_ctrl.md
Name: seq_divider_ctrl

Overview:
- Unsigned restoring sequential divider. It computes one quotient bit per clock.
- Contains the FSM and the shift/subtract datapath. It drives a down-counting iteration counter and uses that counter's zero flag to end the operation.
- It is the consumer of the iteration counter's zero flag. It sits between the operand source (start/operands) and the result consumer (done/quotient/remainder).

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits; legal values are 2..32.
- CNT_W, $clog2(WIDTH), iteration-counter width. This is a localparam derived from WIDTH and cannot be overridden.

Ports:
- clk  input  1  clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request a divide; accepted only in IDLE
- dividend  input  WIDTH  numerator; sampled on the accepted start cycle
- divisor  input  WIDTH  denominator; sampled on the accepted start cycle
- busy  output  1  high from the cycle after start is accepted through the DONE cycle
- done  output  1  one-cycle pulse; results are valid in this cycle
- quotient  output  WIDTH  registered result; held until the next accepted start
- remainder  output  WIDTH  registered result; held until the next accepted start
- div_err  output  1  present only when DIV_ZERO_DETECT_EN is defined

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_err=0.
  - Partial results are discarded.
- States: IDLE, CALC, DONE. The encoding comes from the package.
- IDLE:
  - When start=1, capture dividend into the Q register and divisor into the D register.
  - Clear R (WIDTH+1 bits).
  - Load the counter with WIDTH-1 (ld=1, ce=1).
  - Next state is CALC.
- CALC: each cycle performs one step.
  - {R,Q} <= {R,Q} << 1, then trial = R_shifted - {1'b0,D}.
  - If trial is non-negative (MSB=0): R <= trial and Q[0] <= 1. Otherwise R is unchanged and Q[0] <= 0.
  - Counter decrements (ce=1, ud=0).
  - If the counter zero flag is 1 during this step, the step is the last one and next state is DONE.
  - Exactly WIDTH CALC cycles occur.
- DONE:
  - done=1; quotient <= Q and remainder <= R[WIDTH-1:0], both visible this cycle.
  - Next state is IDLE.
- Latency: start accepted at cycle t, CALC spans t+1..t+WIDTH, done at t+WIDTH+1. Throughput is one divide per WIDTH+2 cycles.
- start while busy, including in DONE, is ignored with no queuing. Operands are don't-care outside the accepted start cycle.
- Back-to-back: start asserted in the IDLE cycle right after DONE is accepted normally.
- Divisor=0 without the feature: the algorithm runs normally and yields quotient = all ones, remainder = dividend, with normal latency.
- All arithmetic is unsigned. The R width of WIDTH+1 prevents overflow of the trial subtraction.

Optional Feature:
- Macro: DIV_ZERO_DETECT_EN.
- Defined:
  - Adds the div_err port.
  - If divisor==0 on the accepted start, the FSM goes IDLE→DONE directly, skipping CALC. done is then at t+1.
  - Results: quotient = all ones, remainder = dividend, div_err=1.
  - div_err holds until the next accepted start, which clears it.
- Undefined:
  - No div_err port and no compare logic.
  - Divisor 0 behaves as in Behaviour.

Decomposition:
- Package seq_divider_pkg contains:
  - the state typedef and encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - a function returning the CNT_W for a given WIDTH;
  - the constant DIV_DEFAULT_WIDTH=8.
- Sub-module div_iter_counter:
  - parameterized CNT_W, async-reset loadable up/down counter;
  - inputs clk, rst, ce, ld, ud, D;
  - output zflag, combinational, set when count==0.
  - This controller always uses it in down mode.

Test Plan:
- 100/7 with WIDTH=8 → done exactly 9 cycles after start, quotient=14, remainder=2; busy high for 9 cycles.
- 255/1 → quotient=255, remainder=0. 5/9 → quotient=0, remainder=5.
- 77/0, macro undefined → quotient=255, remainder=77, done at t+9. Macro defined → done at t+1, div_err=1, quotient=255, remainder=77, and div_err is cleared by the next start.
- start pulsed at t+3 during CALC with different operands → ignored; result is still for the original operands. A second start in the IDLE cycle after DONE is accepted.
- rst asserted at t+4 → busy, done, quotient and remainder go to 0 immediately. A new 200/13 is then accepted, giving quotient=15, remainder=5.
